// File: rtl/afg_pkg.sv
// ---------------------------------------------------------------------------
// afg_pkg
// Shared definitions for the amount/parameter path of the generator.
//   - state_t       : press/hold/auto-repeat FSM encoding
//   - DEF_*         : default width, bounds and step sizes, shared with the
//                     amplitude/frequency parameter registers
// ---------------------------------------------------------------------------
package afg_pkg;

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_HOLD   = 2'd1,
      ST_REPEAT = 2'd2
   } state_t;

   localparam int DEF_WIDTH       = 8;
   localparam int DEF_MIN_AMOUNT  = 0;
   localparam int DEF_MAX_AMOUNT  = 255;
   localparam int DEF_RESET       = 128;
   localparam int DEF_STEP_FINE   = 1;
   localparam int DEF_STEP_COARSE = 16;

endpackage

// File: rtl/amount_sat_adder.sv
// ---------------------------------------------------------------------------
// amount_sat_adder
// Combinational saturating add/subtract clamped to [MIN_AMOUNT, MAX_AMOUNT].
// With b_i = 0 and sub_i = 0 it acts as a plain clamp of a_i.
// Ports:
//   a_i   : base value
//   b_i   : step value
//   sub_i : 1 = a_i - b_i, 0 = a_i + b_i
//   y_o   : clamped result
// ---------------------------------------------------------------------------
module amount_sat_adder #(
   parameter int WIDTH      = 8,
   parameter int MIN_AMOUNT = 0,
   parameter int MAX_AMOUNT = 255
) (
   input  logic [WIDTH-1:0] a_i,
   input  logic [WIDTH-1:0] b_i,
   input  logic             sub_i,
   output logic [WIDTH-1:0] y_o
);

   localparam logic [WIDTH:0]   MIN_W = (WIDTH+1)'(MIN_AMOUNT);
   localparam logic [WIDTH:0]   MAX_W = (WIDTH+1)'(MAX_AMOUNT);
   localparam logic [WIDTH-1:0] MIN_N = WIDTH'(MIN_AMOUNT);
   localparam logic [WIDTH-1:0] MAX_N = WIDTH'(MAX_AMOUNT);

   // One extra bit so neither the sum nor the lower-bound test can wrap.
   logic [WIDTH:0]   a_w;
   logic [WIDTH:0]   b_w;
   logic [WIDTH:0]   sum_w;
   logic [WIDTH-1:0] diff_n;

   assign a_w    = {1'b0, a_i};
   assign b_w    = {1'b0, b_i};
   assign sum_w  = a_w + b_w;
   // Only used when a_i >= MIN + b_i, so the narrow difference cannot underflow.
   assign diff_n = a_i - b_i;

   always_comb begin
      y_o = a_i;
      if (sub_i) begin
         if (a_w < MIN_W + b_w) begin
            y_o = MIN_N;
         end else if (diff_n > MAX_N) begin
            y_o = MAX_N;
         end else begin
            y_o = diff_n;
         end
      end else begin
         if (sum_w > MAX_W) begin
            y_o = MAX_N;
         end else if (sum_w < MIN_W) begin
            y_o = MIN_N;
         end else begin
            y_o = sum_w[WIDTH-1:0];
         end
      end
   end

endmodule

// File: rtl/amount_step_ctrl.sv
// ---------------------------------------------------------------------------
// amount_step_ctrl
// Saturating amount register driven by conditioned Inc/Dec buttons: one step
// per press, auto-repeat while held, fine/coarse step and a clamped load.
// Ports:
//   Clock      : system clock, rising edge
//   Reset      : asynchronous, active-high
//   Inc / Dec  : increment / decrement requests (synchronous)
//   Coarse     : 1 selects STEP_COARSE, sampled at every step
//   Load       : load strobe, overrides Inc/Dec
//   Load_Value : value to load (clamped to bounds)
//   Amount     : current amount (registered)
//   Amount_Upd : one-cycle pulse when Amount changed
//   At_Max     : Amount == MAX_AMOUNT (registered)
//   At_Min     : Amount == MIN_AMOUNT (registered)
// ---------------------------------------------------------------------------
module amount_step_ctrl
   import afg_pkg::*;
#(
   parameter int WIDTH         = DEF_WIDTH,
   parameter int MIN_AMOUNT    = DEF_MIN_AMOUNT,
   parameter int MAX_AMOUNT    = DEF_MAX_AMOUNT,
   parameter int RESET_AMOUNT  = DEF_RESET,
   parameter int STEP_FINE     = DEF_STEP_FINE,
   parameter int STEP_COARSE   = DEF_STEP_COARSE,
   parameter int HOLD_CYCLES   = 1000,
   parameter int REPEAT_CYCLES = 100,
   parameter int CNT_W         = 16
) (
   input  logic             Clock,
   input  logic             Reset,
   input  logic             Inc,
   input  logic             Dec,
   input  logic             Coarse,
   input  logic             Load,
   input  logic [WIDTH-1:0] Load_Value,
   output logic [WIDTH-1:0] Amount,
   output logic             Amount_Upd,
   output logic             At_Max,
   output logic             At_Min
);

   localparam logic [WIDTH-1:0] RESET_N   = WIDTH'(RESET_AMOUNT);
   localparam logic [WIDTH-1:0] MAX_N     = WIDTH'(MAX_AMOUNT);
   localparam logic [WIDTH-1:0] MIN_N     = WIDTH'(MIN_AMOUNT);
   localparam logic [WIDTH-1:0] STEP_F    = WIDTH'(STEP_FINE);
   localparam logic [WIDTH-1:0] STEP_C    = WIDTH'(STEP_COARSE);
   localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(HOLD_CYCLES - 1);
   localparam logic [CNT_W-1:0] REP_LAST  = CNT_W'(REPEAT_CYCLES - 1);

   state_t           state_q, state_d;
   logic             dir_q, dir_d;          // 0 = inc, 1 = dec
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic             inc_dly_q, dec_dly_q;  // previous-cycle Inc/Dec
   logic [WIDTH-1:0] amount_q, amount_d;
   logic             upd_q;
   logic             at_max_q, at_min_q;

   logic             inc_rise, dec_rise;
   logic             active_in, opposite_in;
   logic             step_en, step_dn;
   logic [WIDTH-1:0] step_val, step_res, load_res;

   assign inc_rise    = Inc & ~inc_dly_q;
   assign dec_rise    = Dec & ~dec_dly_q;
   assign active_in   = dir_q ? Dec : Inc;
   assign opposite_in = dir_q ? Inc : Dec;

   amount_sat_adder #(
      .WIDTH      (WIDTH),
      .MIN_AMOUNT (MIN_AMOUNT),
      .MAX_AMOUNT (MAX_AMOUNT)
   ) u_step_add (
      .a_i   (amount_q),
      .b_i   (step_val),
      .sub_i (step_dn),
      .y_o   (step_res)
   );

   // Same saturating path with a zero step is a pure clamp for Load.
   amount_sat_adder #(
      .WIDTH      (WIDTH),
      .MIN_AMOUNT (MIN_AMOUNT),
      .MAX_AMOUNT (MAX_AMOUNT)
   ) u_load_clamp (
      .a_i   (Load_Value),
      .b_i   ({WIDTH{1'b0}}),
      .sub_i (1'b0),
      .y_o   (load_res)
   );

   // State register and all datapath registers.
   always_ff @(posedge Clock or posedge Reset) begin
      if (Reset) begin
         state_q   <= ST_IDLE;
         dir_q     <= 1'b0;
         cnt_q     <= '0;
         inc_dly_q <= 1'b0;
         dec_dly_q <= 1'b0;
         amount_q  <= RESET_N;
         upd_q     <= 1'b0;
         at_max_q  <= (RESET_N == MAX_N);
         at_min_q  <= (RESET_N == MIN_N);
      end else begin
         state_q   <= state_d;
         dir_q     <= dir_d;
         cnt_q     <= cnt_d;
         inc_dly_q <= Inc;
         dec_dly_q <= Dec;
         amount_q  <= amount_d;
         upd_q     <= (amount_d != amount_q);
         at_max_q  <= (amount_d == MAX_N);
         at_min_q  <= (amount_d == MIN_N);
      end
   end

   // Next-state logic; also decides when a step happens and in which direction.
   always_comb begin
      state_d = state_q;
      dir_d   = dir_q;
      cnt_d   = cnt_q;
      step_en = 1'b0;
      step_dn = dir_q;
      if (Load) begin
         state_d = ST_IDLE;
         cnt_d   = '0;
      end else begin
         case (state_q)
            ST_IDLE: begin
               // A rise only counts while the other button is released.
               if (inc_rise && !Dec) begin
                  step_en = 1'b1;
                  step_dn = 1'b0;
                  dir_d   = 1'b0;
                  cnt_d   = '0;
                  state_d = ST_HOLD;
               end else if (dec_rise && !Inc) begin
                  step_en = 1'b1;
                  step_dn = 1'b1;
                  dir_d   = 1'b1;
                  cnt_d   = '0;
                  state_d = ST_HOLD;
               end
            end
            ST_HOLD, ST_REPEAT: begin
               if (!active_in || opposite_in) begin
                  state_d = ST_IDLE;
                  cnt_d   = '0;
               end else if (cnt_q == ((state_q == ST_HOLD) ? HOLD_LAST : REP_LAST)) begin
                  step_en = 1'b1;
                  cnt_d   = '0;
                  state_d = ST_REPEAT;
               end else begin
                  cnt_d = cnt_q + CNT_W'(1);
               end
            end
            default: begin
               state_d = ST_IDLE;
               cnt_d   = '0;
            end
         endcase
      end
   end

   // Output / datapath selection.
   always_comb begin
      step_val = Coarse ? STEP_C : STEP_F;
      amount_d = amount_q;
      if (Load) begin
         amount_d = load_res;
      end else if (step_en) begin
         amount_d = step_res;
      end
   end

   assign Amount     = amount_q;
   assign Amount_Upd = upd_q;
   assign At_Max     = at_max_q;
   assign At_Min     = at_min_q;

endmodule

// File: tb/tb_amount_step_ctrl.sv
module tb_amount_step_ctrl;

   logic       Clock;
   logic       Reset;
   logic       Inc, Dec, Coarse, Load;
   logic [7:0] load_value_a;
   logic [8:0] load_value_b;
   logic [7:0] amount_a;
   logic [8:0] amount_b;
   logic       upd_a, at_max_a, at_min_a;
   logic       upd_b, at_max_b, at_min_b;

   int total = 0;
   int bad   = 0;

   // Default build with a short hold/repeat timing.
   amount_step_ctrl #(
      .HOLD_CYCLES   (4),
      .REPEAT_CYCLES (2)
   ) dut_a (
      .Clock      (Clock),
      .Reset      (Reset),
      .Inc        (Inc),
      .Dec        (Dec),
      .Coarse     (Coarse),
      .Load       (Load),
      .Load_Value (load_value_a),
      .Amount     (amount_a),
      .Amount_Upd (upd_a),
      .At_Max     (at_max_a),
      .At_Min     (at_min_a)
   );

   // 9-bit build with MAX_AMOUNT=200 so an out-of-range load (300) is expressible.
   amount_step_ctrl #(
      .WIDTH         (9),
      .MAX_AMOUNT    (200),
      .HOLD_CYCLES   (4),
      .REPEAT_CYCLES (2)
   ) dut_b (
      .Clock      (Clock),
      .Reset      (Reset),
      .Inc        (Inc),
      .Dec        (Dec),
      .Coarse     (Coarse),
      .Load       (Load),
      .Load_Value (load_value_b),
      .Amount     (amount_b),
      .Amount_Upd (upd_b),
      .At_Max     (at_max_b),
      .At_Min     (at_min_b)
   );

   initial Clock = 1'b0;
   always #5 Clock = ~Clock;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
      end else begin
         $display("ok   %s got=%0d", tag, got);
      end
   endtask

   task automatic tick();
      @(posedge Clock);
      #1;
   endtask

   task automatic ticks(input int n);
      for (int i = 0; i < n; i++) tick();
   endtask

   task automatic do_load(input logic [7:0] v);
      load_value_a = v;
      Load = 1'b1;
      tick();
      Load = 1'b0;
   endtask

   initial begin
      Reset = 1'b1;
      Inc = 1'b0; Dec = 1'b0; Coarse = 1'b0; Load = 1'b0;
      load_value_a = 8'd0;
      load_value_b = 9'd0;
      #2;
      chk("rst_amount", amount_a, 128);
      chk("rst_upd",    upd_a, 0);
      chk("rst_max",    at_max_a, 0);
      chk("rst_min",    at_min_a, 0);
      ticks(2);
      Reset = 1'b0;
      tick();

      // Single 2-cycle Inc pulse: one step, one Upd pulse, no more steps.
      Inc = 1'b1;
      tick();
      chk("pulse_step", amount_a, 129);
      chk("pulse_upd",  upd_a, 1);
      tick();
      chk("pulse_upd_gone", upd_a, 0);
      Inc = 1'b0;
      ticks(6);
      chk("pulse_no_more", amount_a, 129);

      // Coarse step saturating at MAX.
      do_load(8'd250);
      chk("load250", amount_a, 250);
      Coarse = 1'b1;
      Inc = 1'b1;
      tick();
      chk("coarse_sat",     amount_a, 255);
      chk("coarse_sat_max", at_max_a, 1);
      chk("coarse_sat_upd", upd_a, 1);
      Inc = 1'b0;
      ticks(2);
      Inc = 1'b1;
      tick();
      chk("sat_again",     amount_a, 255);
      chk("sat_again_upd", upd_a, 0);
      Inc = 1'b0;
      Coarse = 1'b0;
      ticks(2);

      // Held Inc for 12 cycles: steps at edges 0,4,6,8,10.
      do_load(8'd128);
      chk("load128_upd", upd_a, 1);
      Inc = 1'b1;
      ticks(5);
      chk("hold_after5", amount_a, 130);
      ticks(7);
      chk("hold_after12", amount_a, 133);
      Inc = 1'b0;
      ticks(4);
      chk("hold_release", amount_a, 133);

      // Simultaneous rise: no step.
      do_load(8'd100);
      Inc = 1'b1; Dec = 1'b1;
      ticks(2);
      chk("both_rise", amount_a, 100);
      Inc = 1'b0; Dec = 1'b0;
      tick();
      // Dec held, Inc joins during HOLD: cancel after the first decrement.
      Dec = 1'b1;
      tick();
      chk("dec_first", amount_a, 99);
      tick();
      Inc = 1'b1;
      ticks(6);
      chk("dec_cancel", amount_a, 99);
      Inc = 1'b0; Dec = 1'b0;
      tick();

      // Coarse decrement saturating at MIN.
      do_load(8'd5);
      Coarse = 1'b1;
      Dec = 1'b1;
      tick();
      chk("dec_sat_min", amount_a, 0);
      chk("dec_at_min",  at_min_a, 1);
      Dec = 1'b0;
      Coarse = 1'b0;
      ticks(2);

      // Load with Inc in the same cycle; held Inc must not step afterwards.
      load_value_a = 8'd50;
      load_value_b = 9'd300;
      Load = 1'b1;
      Inc = 1'b1;
      tick();
      Load = 1'b0;
      chk("load_clamp_b",  amount_b, 200);
      chk("load_clamp_mx", at_max_b, 1);
      chk("load_a_ign_inc", amount_a, 50);
      ticks(6);
      chk("held_no_step_a", amount_a, 50);
      chk("held_no_step_b", amount_b, 200);
      Inc = 1'b0;
      tick();
      Dec = 1'b1;
      tick();
      chk("repress_a", amount_a, 49);
      chk("repress_b", amount_b, 199);
      Dec = 1'b0;
      ticks(2);

      // Async reset during REPEAT at Amount 140.
      do_load(8'd136);
      Inc = 1'b1;
      ticks(9);
      chk("pre_rst_140", amount_a, 140);
      #2;
      Reset = 1'b1;
      #1;
      chk("async_rst_amount", amount_a, 128);
      chk("async_rst_max",    at_max_a, 0);
      chk("async_rst_min",    at_min_a, 0);
      chk("async_rst_upd",    upd_a, 0);
      tick();
      Inc = 1'b0;
      tick();
      Reset = 1'b0;
      ticks(4);
      chk("post_rst_idle", amount_a, 128);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
